// File: rtl/avmm_poll_master.sv
// Avalon-MM master: writes one command word to a slave, then polls a result register
// until the value holds steady for STABLE_COUNT comparisons or MAX_POLLS reads elapse.
module avmm_poll_master #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int POLL_GAP     = 4,
  parameter int STABLE_COUNT = 2,
  parameter int MAX_POLLS    = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [ADDR_W-1:0] res_addr,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);
  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int SW = $clog2(STABLE_COUNT + 1);
  localparam int GW = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_READ, S_FINISH} state_t;

  state_t            r_state;
  logic              r_busy, r_done, r_timeout, r_write, r_read, r_prev_valid;
  logic [DATA_W-1:0] r_result, r_writedata;
  logic [ADDR_W-1:0] r_address, r_res_addr;
  logic [PW-1:0]     r_poll;
  logic [SW-1:0]     r_stable;
  logic [GW-1:0]     r_gap;

  logic [PW-1:0]     w_poll_nxt;
  logic [SW-1:0]     w_stable_nxt;
  logic              w_stable_hit, w_poll_hit;

  // r_result always holds the previous read, so it doubles as the comparison value
  assign w_poll_nxt   = r_poll + PW'(1);
  assign w_stable_nxt = (r_prev_valid && (avm_readdata == r_result)) ? r_stable + SW'(1) : '0;
  assign w_stable_hit = (w_stable_nxt == SW'(STABLE_COUNT));
  assign w_poll_hit   = (w_poll_nxt == PW'(MAX_POLLS));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_write      <= 1'b0;
      r_read       <= 1'b0;
      r_prev_valid <= 1'b0;
      r_result     <= '0;
      r_writedata  <= '0;
      r_address    <= '0;
      r_res_addr   <= '0;
      r_poll       <= '0;
      r_stable     <= '0;
      r_gap        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_WRITE;
            r_busy       <= 1'b1;
            r_write      <= 1'b1;
            r_address    <= cmd_addr;
            r_writedata  <= cmd_data;
            r_res_addr   <= res_addr;
            r_result     <= '0;
            r_poll       <= '0;
            r_stable     <= '0;
            r_prev_valid <= 1'b0;
          end
        end
        S_WRITE: begin
          if (!avm_waitrequest) begin
            r_write <= 1'b0;
            r_gap   <= GW'(POLL_GAP);
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap == GW'(1)) begin
            r_read    <= 1'b1;
            r_address <= r_res_addr;
            r_state   <= S_READ;
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end
        S_READ: begin
          if (!avm_waitrequest) begin
            r_read       <= 1'b0;
            r_result     <= avm_readdata;
            r_poll       <= w_poll_nxt;
            r_stable     <= w_stable_nxt;
            r_prev_valid <= 1'b1;
            // stability wins when the last allowed read is also the stable one
            if (w_stable_hit) begin
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else if (w_poll_hit) begin
              r_timeout <= 1'b1;
              r_state   <= S_FINISH;
            end else begin
              r_gap   <= GW'(POLL_GAP);
              r_state <= S_GAP;
            end
          end
        end
        S_FINISH: begin
          r_done    <= 1'b0;
          r_timeout <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign timeout       = r_timeout;
  assign result        = r_result;
  assign avm_address   = r_address;
  assign avm_write     = r_write;
  assign avm_writedata = r_writedata;
  assign avm_read      = r_read;
endmodule

// File: doc/avmm_poll_master.md
Name: avmm_poll_master

Overview:
Avalon-MM master that drives the command/result style slave peripherals in soc_system from FPGA-side logic rather than from the HPS bridge. On a start request it writes one command word to a slave address. It then polls a result address at a fixed interval until the returned value stays constant for a programmable number of consecutive reads, or until a poll limit expires. It reports the final value and a completion or timeout status to the local controller.

Parameters:
ADDR_W, 2, width of avm_address (word address into slave register space)
DATA_W, 32, width of write/read data and result
POLL_GAP, 4, idle cycles between end of one read and start of the next (>=1)
STABLE_COUNT, 2, consecutive equal comparisons required to declare done (>=1)
MAX_POLLS, 1024, maximum read transactions per command before timeout (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
cmd_addr  in  ADDR_W  slave address for command write
cmd_data  in  DATA_W  command word written to slave
res_addr  in  ADDR_W  slave address polled for result
busy  out  1  high from accepted start until done/timeout pulse cycle inclusive
done  out  1  one-cycle pulse: result stable
timeout  out  1  one-cycle pulse: MAX_POLLS reached without stability
result  out  DATA_W  last read value; held until next accepted start
avm_address  out  ADDR_W  Avalon-MM address
avm_write  out  1  Avalon-MM write strobe
avm_writedata  out  DATA_W  Avalon-MM write data
avm_read  out  1  Avalon-MM read strobe
avm_readdata  in  DATA_W  Avalon-MM read data; valid when avm_read && !avm_waitrequest
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset (reset_n low at posedge clk): state IDLE. busy, done, timeout, avm_write, avm_read = 0; result, avm_address, avm_writedata = 0; all counters cleared. Reset mid-transaction drops strobes on that edge; no completion is issued.
- States: IDLE, WRITE, GAP, READ, FINISH.
- IDLE: start=1 latches cmd_addr/cmd_data/res_addr, clears result, poll and stable counters, prev_valid=0. Next state WRITE. Strobes assert the cycle after start.
- WRITE: avm_write=1, avm_address=cmd_addr, avm_writedata=cmd_data held constant. Transfer completes on a cycle with avm_waitrequest=0; then GAP with gap counter=POLL_GAP.
- GAP: no strobes; decrement each cycle; at 1 go to READ.
- READ: avm_read=1, avm_address=res_addr. On avm_waitrequest=0 the transfer completes:
  - capture avm_readdata into result; poll_cnt+1
  - prev_valid=0: set prev_valid, stable_cnt=0
  - prev_valid=1 and value equals previous: stable_cnt+1; otherwise stable_cnt=0
  - stable_cnt reaches STABLE_COUNT: FINISH with done
  - else poll_cnt reaches MAX_POLLS: FINISH with timeout
  - else GAP
  - Stability takes priority over timeout on the same read.
- FINISH: one cycle; exactly one of done/timeout=1, busy=1; next IDLE with busy=0.
- A single read completes in 1 cycle when there is no waitrequest. Read-to-read spacing is POLL_GAP+1 cycles.
- Strobes never both high. Address and data are stable while waitrequest is high. start outside IDLE is ignored.
- Counters are sized to hold MAX_POLLS and STABLE_COUNT without wrap. Equality compares all DATA_W bits.
- avm_waitrequest held high forever hangs in WRITE/READ. This is by design; there is no bus timeout.

Test Plan:
- Defaults. Slave model returns 1..6 incrementing on every read, then 6 forever; start with cmd_data=10. Required: one write of 10 to cmd_addr; reads 1,2,3,4,5,6,6,6; done pulse once; result=6; 8 reads total; timeout never high.
- waitrequest held 3 cycles on the write and on every read. Required: avm_address, avm_writedata and the strobe stay constant during the stall; same final result=6 and read count as above.
- MAX_POLLS=8, slave returns an ever-incrementing value. Required: exactly 8 reads; timeout pulse; result equals the 8th read value; done stays 0.
- Constant-value slave (0xDEADBEEF), STABLE_COUNT=2, MAX_POLLS=3. Required: the 3rd read meets both stability and the poll limit; done=1 and timeout=0.
- start pulsed during READ. Required: ignored, no second write. Then reset_n low for one cycle mid-READ. Required: next edge has avm_read=0, busy=0, result=0, no done/timeout; a new start afterwards behaves normally.
- Back-to-back commands: start asserted on the cycle after FINISH. Required: accepted; result cleared; new write issued the following cycle.
